// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM master that sequences a complete PLL reconfiguration: mode, N, M, masked C
// counters, start, status poll and lock wait. Define PLL_SEQ_VERIFY_EN for counter read-back.
module pll_reconfig_sequencer #(
  parameter int NUM_CNT     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic                    cfg_start,
  input  logic [17:0]             cfg_n,
  input  logic [17:0]             cfg_m,
  input  logic [18*NUM_CNT-1:0]   cfg_c,
  input  logic [NUM_CNT-1:0]      cfg_c_mask,
  input  logic                    pll_locked,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_error,
  output logic [1:0]              err_code,
  output logic [5:0]              mgmt_address,
  output logic                    mgmt_read,
  output logic                    mgmt_write,
  output logic [31:0]             mgmt_writedata,
  input  logic [31:0]             mgmt_readdata,
  input  logic                    mgmt_waitrequest
);

  localparam int IW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CNT - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC - 1);

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;

  typedef enum logic [3:0] {
    IDLE, MODE, WR_N, WR_M, WR_C, START, POLL, LOCK, VERIFY, DONE, ERR
  } state_t;

  state_t             state;
  logic [17:0]        n_q;
  logic [17:0]        m_q;
  logic [17:0]        c_q [NUM_CNT];
  logic [NUM_CNT-1:0] mask_q;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      timer;
`ifdef PLL_SEQ_VERIFY_EN
  logic [1:0]         vstep;
`endif

  logic        bus_idle;
  logic        xfer_done;
  logic        last_idx;
  logic        timed_out;
  logic [31:0] sel_word;
  logic        unused_rd;

  assign bus_idle  = !mgmt_read && !mgmt_write;
  assign xfer_done = (mgmt_read || mgmt_write) && !mgmt_waitrequest;
  assign last_idx  = (idx == LAST_IDX);
  assign timed_out = (timer == TMAX);
  assign sel_word  = {9'b0, 5'(idx), c_q[idx]};
  assign unused_rd = ^mgmt_readdata[31:1];

  // Configuration snapshot taken only when a start is accepted
  always_ff @(posedge clk_clk) begin
    if (state == IDLE && cfg_start) begin
      n_q    <= cfg_n;
      m_q    <= cfg_m;
      mask_q <= cfg_c_mask;
      for (int i = 0; i < NUM_CNT; i++) c_q[i] <= cfg_c[18*i +: 18];
    end
  end

  // A bus state issues its access while the bus is idle and advances on completion,
  // which leaves the mandatory idle cycle between consecutive transactions.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state          <= IDLE;
      mgmt_read      <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      err_code       <= 2'd0;
      idx            <= '0;
      timer          <= '0;
`ifdef PLL_SEQ_VERIFY_EN
      vstep          <= 2'd0;
`endif
    end else begin
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        IDLE: if (cfg_start) begin
          cfg_busy <= 1'b1;
          err_code <= 2'd0;
          idx      <= '0;
          state    <= MODE;
        end
        MODE: if (bus_idle) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= ADDR_MODE;
          mgmt_writedata <= 32'd1;
        end else if (xfer_done) begin
          mgmt_write <= 1'b0;
          state      <= WR_N;
        end
        WR_N: if (bus_idle) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= ADDR_N;
          mgmt_writedata <= {14'b0, n_q};
        end else if (xfer_done) begin
          mgmt_write <= 1'b0;
          state      <= WR_M;
        end
        WR_M: if (bus_idle) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= ADDR_M;
          mgmt_writedata <= {14'b0, m_q};
        end else if (xfer_done) begin
          mgmt_write <= 1'b0;
          state      <= WR_C;
        end
        WR_C: if (bus_idle) begin
          if (mask_q[idx]) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= ADDR_C;
            mgmt_writedata <= sel_word;
          end else if (last_idx) begin
            idx   <= '0;
            state <= START;
          end else begin
            idx <= idx + 1'b1;
          end
        end else if (xfer_done) begin
          mgmt_write <= 1'b0;
          if (last_idx) begin
            idx   <= '0;
            state <= START;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        START: if (bus_idle) begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= ADDR_START;
          mgmt_writedata <= 32'd1;
        end else if (xfer_done) begin
          mgmt_write <= 1'b0;
          timer      <= '0;
          state      <= POLL;
        end
        POLL: begin
          if (xfer_done && mgmt_readdata[0]) begin
            mgmt_read <= 1'b0;
            timer     <= '0;
            state     <= LOCK;
          end else if (timed_out) begin
            // Any outstanding status read is abandoned
            mgmt_read <= 1'b0;
            cfg_error <= 1'b1;
            cfg_busy  <= 1'b0;
            err_code  <= 2'd1;
            state     <= ERR;
          end else begin
            timer <= timer + 1'b1;
            if (bus_idle) begin
              mgmt_read    <= 1'b1;
              mgmt_address <= ADDR_STATUS;
            end else if (xfer_done) begin
              mgmt_read <= 1'b0;
            end
          end
        end
        LOCK: begin
          if (pll_locked) begin
`ifdef PLL_SEQ_VERIFY_EN
            vstep <= 2'd0;
            idx   <= '0;
            state <= VERIFY;
`else
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= DONE;
`endif
          end else if (timed_out) begin
            cfg_error <= 1'b1;
            cfg_busy  <= 1'b0;
            err_code  <= 2'd2;
            state     <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef PLL_SEQ_VERIFY_EN
        // vstep: 0 read N, 1 read M, 2 select C[idx] (rewrite same word), 3 read C[idx]
        VERIFY: begin
          if (bus_idle) begin
            case (vstep)
              2'd0: begin
                mgmt_read    <= 1'b1;
                mgmt_address <= ADDR_N;
              end
              2'd1: begin
                mgmt_read    <= 1'b1;
                mgmt_address <= ADDR_M;
              end
              2'd2: begin
                if (mask_q[idx]) begin
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= ADDR_C;
                  mgmt_writedata <= sel_word;
                end else if (last_idx) begin
                  cfg_done <= 1'b1;
                  cfg_busy <= 1'b0;
                  state    <= DONE;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
              default: begin
                mgmt_read    <= 1'b1;
                mgmt_address <= ADDR_C;
              end
            endcase
          end else if (xfer_done) begin
            mgmt_read  <= 1'b0;
            mgmt_write <= 1'b0;
            if ((vstep == 2'd0 && mgmt_readdata[17:0] != n_q) ||
                (vstep == 2'd1 && mgmt_readdata[17:0] != m_q) ||
                (vstep == 2'd3 && mgmt_readdata[17:0] != c_q[idx])) begin
              cfg_error <= 1'b1;
              cfg_busy  <= 1'b0;
              err_code  <= 2'd3;
              state     <= ERR;
            end else if (vstep == 2'd3 && last_idx) begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= DONE;
            end else if (vstep == 2'd3) begin
              idx   <= idx + 1'b1;
              vstep <= 2'd2;
            end else begin
              vstep <= vstep + 2'd1;
            end
          end
        end
`endif
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Self-checking bench for pll_reconfig_sequencer: randomized configurations against a
// transaction-list reference model, with a behavioural management slave and PLL lock source.
module tb_pll_reconfig_sequencer;

  localparam int NC = 4;
  localparam int TO = 16;

  logic               clk_clk;
  logic               reset_reset;
  logic               cfg_start;
  logic [17:0]        cfg_n;
  logic [17:0]        cfg_m;
  logic [18*NC-1:0]   cfg_c;
  logic [NC-1:0]      cfg_c_mask;
  logic               pll_locked;
  logic               cfg_busy;
  logic               cfg_done;
  logic               cfg_error;
  logic [1:0]         err_code;
  logic [5:0]         mgmt_address;
  logic               mgmt_read;
  logic               mgmt_write;
  logic [31:0]        mgmt_writedata;
  logic [31:0]        mgmt_readdata;
  logic               mgmt_waitrequest;

  pll_reconfig_sequencer #(.NUM_CNT(NC), .TIMEOUT_CYC(TO)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .cfg_start(cfg_start),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_c_mask(cfg_c_mask),
    .pll_locked(pll_locked), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .err_code(err_code), .mgmt_address(mgmt_address),
    .mgmt_read(mgmt_read), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs
  int max_stall = 0;
  int force_addr = -1;
  int force_len = 0;
  bit status_ok = 1;
  int status_after = 0;
  int lock_mode = 1;
  bit corrupt_m = 0;

  // Slave / monitor state
  bit          active = 0;
  int          remain = 0;
  bit          prev_stall = 0;
  logic [5:0]  s_addr;
  logic [31:0] s_data;
  logic        s_rd, s_wr;
  int          stab_err = 0;
  int          both_err = 0;
  int          forced_cycles = 0;
  int          status_reads = 0;
  logic [17:0] reg_n = '0, reg_m = '0;
  logic [17:0] reg_c [32];
  logic [4:0]  reg_sel = '0;

  bit          log_wr [$];
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  logic [5:0]  exp_addr [$];
  logic [31:0] exp_data [$];

  // Management slave and lock source, evaluated on the falling edge
  always @(negedge clk_clk) begin
    if (mgmt_read && mgmt_write) both_err++;
    if (mgmt_read || mgmt_write) begin
      if (prev_stall && (mgmt_address !== s_addr || mgmt_writedata !== s_data ||
                         mgmt_read !== s_rd || mgmt_write !== s_wr)) stab_err++;
      if (!active) begin
        active = 1;
        if (force_addr >= 0 && int'(mgmt_address) == force_addr) remain = force_len;
        else remain = $urandom_range(0, max_stall);
      end else if (remain > 0) begin
        remain--;
      end
      mgmt_waitrequest = (remain != 0);
      if (force_addr >= 0 && int'(mgmt_address) == force_addr && mgmt_write) forced_cycles++;
      mgmt_readdata = $urandom() & 32'hFFFF_FFFE;
      case (mgmt_address)
        6'h01: mgmt_readdata[0] = status_ok && (status_reads >= status_after);
        6'h03: mgmt_readdata[17:0] = reg_n;
        6'h04: mgmt_readdata[17:0] = reg_m ^ (corrupt_m ? 18'h8 : 18'h0);
        6'h05: mgmt_readdata[17:0] = reg_c[reg_sel];
        default: ;
      endcase
      if (!mgmt_waitrequest) begin
        log_wr.push_back(mgmt_write);
        log_addr.push_back(mgmt_address);
        log_data.push_back(mgmt_writedata);
        if (mgmt_read && mgmt_address == 6'h01) status_reads++;
        if (mgmt_write && mgmt_address == 6'h03) reg_n = mgmt_writedata[17:0];
        if (mgmt_write && mgmt_address == 6'h04) reg_m = mgmt_writedata[17:0];
        if (mgmt_write && mgmt_address == 6'h05) begin
          reg_sel = mgmt_writedata[22:18];
          reg_c[mgmt_writedata[22:18]] = mgmt_writedata[17:0];
        end
      end
      prev_stall = mgmt_waitrequest;
      s_addr = mgmt_address; s_data = mgmt_writedata; s_rd = mgmt_read; s_wr = mgmt_write;
    end else begin
      active = 0;
      prev_stall = 0;
      mgmt_waitrequest = 1'b0;
    end
    case (lock_mode)
      0: pll_locked = 1'b0;
      1: pll_locked = 1'b1;
      default: pll_locked = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference: the ordered write list a successful sequence must produce before polling
  function automatic void build_expected(input logic [17:0] n, input logic [17:0] m,
                                         input logic [18*NC-1:0] c, input logic [NC-1:0] mask);
    exp_addr.delete(); exp_data.delete();
    exp_addr.push_back(6'h00); exp_data.push_back(32'd1);
    exp_addr.push_back(6'h03); exp_data.push_back({14'b0, n});
    exp_addr.push_back(6'h04); exp_data.push_back({14'b0, m});
    for (int i = 0; i < NC; i++)
      if (mask[i]) begin
        exp_addr.push_back(6'h05);
        exp_data.push_back({9'b0, 5'(i), c[18*i +: 18]});
      end
    exp_addr.push_back(6'h02); exp_data.push_back(32'd1);
  endfunction

  function automatic int first_write_diff();
    int j = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_wr[i]) begin
        if (j < exp_addr.size() && (log_addr[i] !== exp_addr[j] || log_data[i] !== exp_data[j]))
          return j;
        j++;
      end
    if (j < exp_addr.size()) return j;
    return -1;
  endfunction

  function automatic int count_writes();
    int k = 0;
    foreach (log_wr[i]) if (log_wr[i]) k++;
    return k;
  endfunction

  function automatic int success_writes(input logic [NC-1:0] mask);
    int k = exp_addr.size();
`ifdef PLL_SEQ_VERIFY_EN
    k += $countones(mask);
`else
    k += 0 * $countones(mask);
`endif
    return k;
  endfunction

  task automatic randomize_cfg();
    cfg_n = 18'($urandom());
    cfg_m = 18'($urandom());
    for (int i = 0; i < NC; i++) cfg_c[18*i +: 18] = 18'($urandom());
    cfg_c_mask = NC'($urandom());
  endtask

  task automatic clear_log();
    log_wr.delete(); log_addr.delete(); log_data.delete();
    status_reads = 0; stab_err = 0; both_err = 0; forced_cycles = 0;
  endtask

  // Stimulus driver: one start request, then sample until the sequence ends or the budget runs out
  task automatic run_config(input int repulse_at, output bit fin, output int dones,
                            output int errs, output int to_read, output bit busy_acc);
    clear_log();
    fin = 0; dones = 0; errs = 0; to_read = -1;
    cfg_start = 1'b1;
    @(posedge clk_clk); #1;
    cfg_start = 1'b0;
    busy_acc = cfg_busy;
    for (int k = 1; k <= 400 && !fin; k++) begin
      cfg_start = (k == repulse_at);
      if (k == repulse_at) begin
        cfg_n = ~cfg_n; cfg_m = ~cfg_m; cfg_c = ~cfg_c; cfg_c_mask = ~cfg_c_mask;
      end
      @(posedge clk_clk); #1;
      if (mgmt_read && to_read < 0) to_read = k;
      dones += int'(cfg_done);
      errs  += int'(cfg_error);
      if (!cfg_busy && (dones + errs) > 0) fin = 1;
    end
    cfg_start = 1'b0;
    repeat (4) begin
      @(posedge clk_clk); #1;
      dones += int'(cfg_done);
      errs  += int'(cfg_error);
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (2) @(posedge clk_clk);
    #1;
    checks++; if (mgmt_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b want 0", mgmt_read); end
    checks++; if (mgmt_write !== 1'b0) begin errors++; $display("FAIL rst_write got %b want 0", mgmt_write); end
    checks++; if (mgmt_address !== 6'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mgmt_address); end
    checks++; if (mgmt_writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mgmt_writedata); end
    checks++; if ({cfg_busy, cfg_done, cfg_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {cfg_busy, cfg_done, cfg_error}); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err_code got %0d want 0", err_code); end
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
  endtask

  task automatic test_full_mask();
    bit fin, ba; int d, e, tr, diff;
    max_stall = 0; force_addr = -1; status_ok = 1; status_after = 0; lock_mode = 1;
    randomize_cfg(); cfg_c_mask = '1;
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(0, fin, d, e, tr, ba);
    diff = first_write_diff();
    checks++; if (!fin) begin errors++; $display("FAIL full_finished got 0 want 1"); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL full_busy_accept got %b want 1", ba); end
    checks++; if (tr != 2*(4+NC)+1) begin errors++; $display("FAIL full_start_to_poll got %0d want %0d", tr, 2*(4+NC)+1); end
    checks++; if (diff != -1) begin errors++; $display("FAIL full_write_seq first bad index %0d want -1", diff); end
    checks++; if (count_writes() != success_writes(cfg_c_mask)) begin errors++; $display("FAIL full_write_count got %0d want %0d", count_writes(), success_writes(cfg_c_mask)); end
    checks++; if (d != 1 || e != 0) begin errors++; $display("FAIL full_pulses got done=%0d err=%0d want 1/0", d, e); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL full_err_code got %0d want 0", err_code); end
    checks++; if (both_err != 0) begin errors++; $display("FAIL full_rd_wr_both got %0d want 0", both_err); end
  endtask

  task automatic test_mask_0101();
    bit fin, ba; int d, e, tr, diff;
    max_stall = 2; force_addr = -1; status_ok = 1; status_after = 2; lock_mode = 2;
    randomize_cfg(); cfg_c_mask = 4'b0101;
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(5, fin, d, e, tr, ba);
    diff = first_write_diff();
    checks++; if (!fin) begin errors++; $display("FAIL m0101_finished got 0 want 1"); end
    checks++; if (diff != -1) begin errors++; $display("FAIL m0101_write_seq first bad index %0d want -1", diff); end
    checks++; if (count_writes() != success_writes(4'b0101)) begin errors++; $display("FAIL m0101_write_count got %0d want %0d", count_writes(), success_writes(4'b0101)); end
    checks++; if (d != 1 || e != 0) begin errors++; $display("FAIL m0101_pulses got done=%0d err=%0d want 1/0", d, e); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL m0101_stable got %0d want 0", stab_err); end
  endtask

  task automatic test_stall_wr_m();
    bit fin, ba; int d, e, tr, diff;
    max_stall = 0; force_addr = 4; force_len = 5; status_ok = 1; status_after = 0; lock_mode = 1;
    randomize_cfg();
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(0, fin, d, e, tr, ba);
    diff = first_write_diff();
    force_addr = -1;
    checks++; if (forced_cycles != 6) begin errors++; $display("FAIL stall_cycles got %0d want 6", forced_cycles); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stab_err); end
    checks++; if (diff != -1) begin errors++; $display("FAIL stall_write_seq first bad index %0d want -1", diff); end
    checks++; if (count_writes() != success_writes(cfg_c_mask)) begin errors++; $display("FAIL stall_write_count got %0d want %0d", count_writes(), success_writes(cfg_c_mask)); end
    checks++; if (d != 1) begin errors++; $display("FAIL stall_done got %0d want 1", d); end
  endtask

  task automatic test_poll_timeout();
    bit fin, ba; int d, e, tr, diff, n0;
    max_stall = 0; force_addr = -1; status_ok = 0; lock_mode = 1;
    randomize_cfg();
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(0, fin, d, e, tr, ba);
    diff = first_write_diff();
    n0 = log_addr.size();
    repeat (10) @(posedge clk_clk);
    #1;
    checks++; if (e != 1 || d != 0) begin errors++; $display("FAIL poll_pulses got done=%0d err=%0d want 0/1", d, e); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL poll_err_code got %0d want 1", err_code); end
    checks++; if (diff != -1) begin errors++; $display("FAIL poll_write_seq first bad index %0d want -1", diff); end
    checks++; if (status_reads < TO/2 - 1 || status_reads > TO/2 + 1) begin errors++; $display("FAIL poll_reads got %0d want about %0d", status_reads, TO/2); end
    checks++; if (log_addr.size() != n0 || mgmt_read || mgmt_write) begin errors++; $display("FAIL poll_quiet got %0d extra transactions want 0", log_addr.size() - n0); end
    status_ok = 1;
  endtask

  task automatic test_lock_timeout();
    bit fin, ba; int d, e, tr;
    max_stall = 1; force_addr = -1; status_ok = 1; status_after = 1; lock_mode = 0;
    randomize_cfg();
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(0, fin, d, e, tr, ba);
    checks++; if (e != 1 || d != 0) begin errors++; $display("FAIL lock_pulses got done=%0d err=%0d want 0/1", d, e); end
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL lock_err_code got %0d want 2", err_code); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL lock_busy got %b want 0", cfg_busy); end
    lock_mode = 1;
  endtask

  task automatic test_reset_mid();
    bit fin, ba, seen; int d, e, tr, diff;
    max_stall = 1; force_addr = -1; status_ok = 1; status_after = 0; lock_mode = 1;
    randomize_cfg(); cfg_c_mask = '1;
    clear_log();
    cfg_start = 1'b1;
    @(posedge clk_clk); #1;
    cfg_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk_clk); #1;
      if (mgmt_write && mgmt_address == 6'h05) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_reach_wr_c got 0 want 1"); end
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    checks++; if (mgmt_read !== 1'b0 || mgmt_write !== 1'b0) begin errors++; $display("FAIL rmid_strobes got rd=%b wr=%b want 0/0", mgmt_read, mgmt_write); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", cfg_busy); end
    reset_reset = 1'b0;
    randomize_cfg();
    build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
    run_config(0, fin, d, e, tr, ba);
    diff = first_write_diff();
    checks++; if (!fin || d != 1 || e != 0) begin errors++; $display("FAIL rmid_restart got fin=%0d done=%0d err=%0d want 1/1/0", fin, d, e); end
    checks++; if (diff != -1) begin errors++; $display("FAIL rmid_write_seq first bad index %0d want -1", diff); end
  endtask

  task automatic test_back_to_back();
    bit fin, ba; int d, e, tr, diff;
    force_addr = -1; status_ok = 1; lock_mode = 2;
    for (int it = 0; it < 5; it++) begin
      max_stall = $urandom_range(0, 3);
      status_after = $urandom_range(0, 1);
      randomize_cfg();
      if (it == 0) cfg_c_mask = '0;
      build_expected(cfg_n, cfg_m, cfg_c, cfg_c_mask);
      run_config(0, fin, d, e, tr, ba);
      diff = first_write_diff();
      checks++; if (!fin || d != 1 || e != 0) begin errors++; $display("FAIL b2b_%0d_result got fin=%0d done=%0d err=%0d want 1/1/0", it, fin, d, e); end
      checks++; if (diff != -1) begin errors++; $display("FAIL b2b_%0d_write_seq first bad index %0d want -1", it, diff); end
      checks++; if (count_writes() != success_writes(cfg_c_mask)) begin errors++; $display("FAIL b2b_%0d_write_count got %0d want %0d", it, count_writes(), success_writes(cfg_c_mask)); end
      checks++; if (stab_err != 0 || both_err != 0) begin errors++; $display("FAIL b2b_%0d_bus_rules got stab=%0d both=%0d want 0/0", it, stab_err, both_err); end
    end
  endtask

`ifdef PLL_SEQ_VERIFY_EN
  task automatic test_verify_mismatch();
    bit fin, ba; int d, e, tr;
    max_stall = 1; force_addr = -1; status_ok = 1; status_after = 0; lock_mode = 1;
    corrupt_m = 1;
    randomize_cfg();
    run_config(0, fin, d, e, tr, ba);
    corrupt_m = 0;
    checks++; if (e != 1 || d != 0) begin errors++; $display("FAIL verify_pulses got done=%0d err=%0d want 0/1", d, e); end
    checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL verify_err_code got %0d want 3", err_code); end
  endtask
`endif

  initial begin
    reset_reset = 1'b1;
    cfg_start = 1'b0;
    cfg_n = '0; cfg_m = '0; cfg_c = '0; cfg_c_mask = '0;
    mgmt_readdata = '0;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    for (int i = 0; i < 32; i++) reg_c[i] = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    test_reset();
    test_full_mask();
    test_mask_0101();
    test_stall_wr_m();
    test_poll_timeout();
    test_lock_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef PLL_SEQ_VERIFY_EN
    test_verify_mismatch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
